fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch sequencer; the consumer of the program counter's address output and the source of its increment strobe. Each fetch presents the PC value to program memory over a rd/ready handshake and captures a 1- or 2-byte instruction (opcode plus optional immediate). It raises pc_enable once per byte consumed and hands the instruction to the decoder over a valid/ack handshake. Branch redirection is outside this block: the decoder loads the PC directly and pulses flush here.

Parameters:
ADDR_W, 8, width of pc_in and mem_addr
DATA_W, 8, width of mem_data, ir_opcode, ir_operand
TIMEOUT_CYCLES, 16, wait-state limit; used only with FETCH_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; fetching is allowed while high
pc_in  in  ADDR_W  current program counter value
pc_enable  out  1  combinational increment strobe to the PC
mem_addr  out  ADDR_W  registered program-memory address
mem_rd  out  1  registered read request
mem_data  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  read completes this cycle
ir_opcode  out  DATA_W  captured opcode
ir_operand  out  DATA_W  captured immediate; 0 for 1-byte instructions
instr_valid  out  1  instruction available
instr_ack  in  1  decoder consumed the instruction
flush  in  1  abandon the current fetch or instruction
fetch_err  out  1  1-cycle timeout pulse (FETCH_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: state IDLE, mem_addr 0, mem_rd 0, ir_opcode 0, ir_operand 0, instr_valid 0, fetch_err 0, timeout counter 0.
- States: IDLE, ISSUE_OP, WAIT_OP, ISSUE_IMM, WAIT_IMM, HOLD.
- IDLE: when run=1, go to ISSUE_OP.
- ISSUE_OP: mem_addr<=pc_in, mem_rd<=1, go to WAIT_OP.
- WAIT_OP: mem_rd stays high until mem_ready=1. On mem_ready:
  - ir_opcode<=mem_data and mem_rd<=0.
  - pc_enable=1 in that same cycle, so the PC increments on the capturing edge.
  - If mem_data[7]=1 (2-byte instruction), go to ISSUE_IMM; otherwise ir_operand<=0, instr_valid<=1, go to HOLD.
- ISSUE_IMM / WAIT_IMM: same as the opcode states. On mem_ready: ir_operand<=mem_data, pc_enable=1, instr_valid<=1, go to HOLD.
- pc_enable = (state is WAIT_OP or WAIT_IMM) AND mem_ready AND NOT flush AND NOT reset. It is never asserted in any other state.
- HOLD: ir_opcode, ir_operand and instr_valid are held stable until instr_ack=1. On ack: instr_valid<=0, then go to ISSUE_OP if run=1, else IDLE. Back-to-back throughput is therefore one instruction per 3 cycles (1-byte, zero-wait memory).
- Latency: with zero-wait memory, a 1-byte instruction shows instr_valid 2 cycles after ISSUE_OP is entered; a 2-byte instruction, 4 cycles.
- run deasserted mid-instruction: the current instruction completes and is delivered; the block returns to IDLE after ack.
- flush, any non-IDLE state: instr_valid<=0, mem_rd<=0, go to ISSUE_OP if run=1, else IDLE. Data arriving with mem_ready in the same cycle is discarded and no pc_enable is issued. flush overrides instr_ack.
- instr_ack outside HOLD is ignored. mem_ready outside the WAIT states is ignored.
- Address wrap: pc_in 0xFF followed by 0x00 needs no special handling.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: a counter runs while in WAIT_OP or WAIT_IMM and clears on entry to either state. If it reaches TIMEOUT_CYCLES without mem_ready, the block drops mem_rd, pulses fetch_err for 1 cycle, discards any partial instruction and goes to IDLE. mem_ready in the terminal cycle wins over the timeout.
- Not defined: waits indefinitely; no counter is instantiated; fetch_err is tied to 0.

Decomposition:
- Shared package cpu_pkg: the state encoding enum; the LONG_OP_BIT=7 constant (opcode bit marking 2-byte instructions); DATA_W and ADDR_W defaults.
- No sub-module is needed; the timeout counter stays inline, guarded by the macro.

Test Plan:
- Reset, run=1, pc starts at 0x00, mem[0x00]=0x12, zero-wait memory -> mem_addr=0x00; exactly one pc_enable pulse; ir_opcode=0x12, ir_operand=0x00, instr_valid high until ack.
- mem[0x01]=0x85, mem[0x02]=0x3C -> two pc_enable pulses; mem_addr 0x01 then 0x02; ir_opcode=0x85, ir_operand=0x3C.
- 3 wait states on the opcode read -> mem_rd high for 4 cycles; pc_enable only in the mem_ready cycle; PC advances by exactly 1.
- flush asserted in the same cycle as mem_ready in WAIT_IMM -> no pc_enable, instr_valid stays 0; the next ISSUE_OP latches the newly loaded PC value (e.g. 0x18).
- instr_ack held low for 5 cycles in HOLD -> outputs stable and no memory activity; ack -> ISSUE_OP next cycle; run=0 at ack -> IDLE.
- With FETCH_TIMEOUT_EN, mem_ready never asserted -> fetch_err pulses after 16 wait cycles, mem_rd=0, state IDLE; reset asserted mid-WAIT -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, long-opcode marker bit and bus-width defaults.
package cpu_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_DATA_W = 8;

  // Opcode bit that marks a 2-byte (opcode + immediate) instruction.
  localparam int unsigned LONG_OP_BIT = 7;

  typedef enum logic [2:0] {
    StIdle,
    StIssueOp,
    StWaitOp,
    StIssueImm,
    StWaitImm,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode (+ optional immediate) over rd/ready, strobes the PC.
// Optional wait-state timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] ir_opcode,
  output logic [DATA_W-1:0] ir_operand,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              flush,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              valid_q, valid_d;
  logic              timeout_hit;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    valid_d    = valid_q;
    pc_enable  = 1'b0;

    // Flush outranks ack and any data returning in the same cycle.
    if (flush && (state_q != StIdle)) begin
      valid_d  = 1'b0;
      mem_rd_d = 1'b0;
      state_d  = run ? StIssueOp : StIdle;
    end else if (timeout_hit) begin
      valid_d  = 1'b0;
      mem_rd_d = 1'b0;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) state_d = StIssueOp;
        end
        StIssueOp: begin
          mem_addr_d = pc_in;
          mem_rd_d   = 1'b1;
          state_d    = StWaitOp;
        end
        StWaitOp: begin
          if (mem_ready) begin
            pc_enable = !reset;
            opcode_d  = mem_data;
            mem_rd_d  = 1'b0;
            if (mem_data[LONG_OP_BIT]) begin
              state_d = StIssueImm;
            end else begin
              operand_d = '0;
              valid_d   = 1'b1;
              state_d   = StHold;
            end
          end
        end
        StIssueImm: begin
          // The PC has already advanced past the opcode byte.
          mem_addr_d = pc_in;
          mem_rd_d   = 1'b1;
          state_d    = StWaitImm;
        end
        StWaitImm: begin
          if (mem_ready) begin
            pc_enable = !reset;
            operand_d = mem_data;
            mem_rd_d  = 1'b0;
            valid_d   = 1'b1;
            state_d   = StHold;
          end
        end
        StHold: begin
          if (instr_ack) begin
            valid_d = 1'b0;
            state_d = run ? StIssueOp : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fetch_err_q;
  logic            in_wait;

  assign in_wait = (state_q == StWaitOp) || (state_q == StWaitImm);

  // Zero outside the wait states, so the count restarts on every entry.
  always_comb begin
    cnt_d = '0;
    if (in_wait) cnt_d = cnt_q + 1'b1;
  end

  // The terminal wait cycle still accepts data if mem_ready arrives.
  assign timeout_hit = in_wait && !mem_ready && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fetch_err_q <= timeout_hit && !flush;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign fetch_err          = 1'b0;
`endif

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign ir_opcode   = opcode_q;
  assign ir_operand  = operand_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small PC and program-memory model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, run, flush, instr_ack;
  logic       pc_enable, mem_rd, mem_ready, instr_valid, fetch_err;
  logic [7:0] pc, mem_addr, mem_data, ir_opcode, ir_operand;
  logic [7:0] mem [256];
  logic       pc_load = 1'b0;
  logic [7:0] pc_load_val = 8'h00;
  int unsigned waits = 0;
  int unsigned wcnt = 0;
  int unsigned en_cnt = 0;
  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .pc_in      (pc),
    .pc_enable  (pc_enable),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .ir_opcode  (ir_opcode),
    .ir_operand (ir_operand),
    .instr_valid(instr_valid),
    .instr_ack  (instr_ack),
    .flush      (flush),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory answers after `waits` wait states; PC loads or increments like the real one.
  assign mem_ready = mem_rd && (wcnt == waits);
  assign mem_data  = mem[mem_addr];

  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_enable) pc <= pc + 8'd1;
    if (pc_enable) en_cnt <= en_cnt + 1;
    if (mem_rd && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; flush = 1'b0; instr_ack = 1'b0;
    pc_load = 1'b1; pc_load_val = 8'h00;
    tick(); tick();
    reset = 1'b0; pc_load = 1'b0;
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL reset_mem_rd: got %0b want 0", mem_rd); end
    tests++; if (ir_opcode !== 8'h00) begin fails++; $display("FAIL reset_opcode: got %0h want 0", ir_opcode); end
    tests++; if (ir_operand !== 8'h00) begin fails++; $display("FAIL reset_operand: got %0h want 0", ir_operand); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", fetch_err); end
    tests++; if (pc_enable !== 1'b0) begin fails++; $display("FAIL reset_pc_en: got %0b want 0", pc_enable); end
  endtask

  task automatic test_one_byte();
    int unsigned en0;
    en0 = en_cnt;
    mem[8'h00] = 8'h12;
    run = 1'b1;
    tick();  // ISSUE_OP
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL one_issue_rd: got %0b want 0", mem_rd); end
    tick();  // WAIT_OP, data ready
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL one_addr: got %0h want 0", mem_addr); end
    tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL one_rd: got %0b want 1", mem_rd); end
    tests++; if (pc_enable !== 1'b1) begin fails++; $display("FAIL one_pc_en: got %0b want 1", pc_enable); end
    tick();  // HOLD
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL one_valid: got %0b want 1", instr_valid); end
    tests++; if (ir_opcode !== 8'h12) begin fails++; $display("FAIL one_opcode: got %0h want 12", ir_opcode); end
    tests++; if (ir_operand !== 8'h00) begin fails++; $display("FAIL one_operand: got %0h want 0", ir_operand); end
    tests++; if (en_cnt - en0 !== 1) begin fails++; $display("FAIL one_pc_pulses: got %0d want 1", en_cnt - en0); end
    tests++; if (pc !== 8'h01) begin fails++; $display("FAIL one_pc: got %0h want 1", pc); end
    tick();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL one_valid_held: got %0b want 1", instr_valid); end
  endtask

  task automatic test_two_byte();
    int unsigned en0;
    en0 = en_cnt;
    mem[8'h01] = 8'h85;
    mem[8'h02] = 8'h3C;
    instr_ack = 1'b1;
    tick();  // ISSUE_OP
    instr_ack = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL two_ack_clear: got %0b want 0", instr_valid); end
    tick();  // WAIT_OP
    tests++; if (mem_addr !== 8'h01) begin fails++; $display("FAIL two_addr_op: got %0h want 1", mem_addr); end
    tick();  // ISSUE_IMM
    tests++; if (ir_opcode !== 8'h85) begin fails++; $display("FAIL two_opcode_early: got %0h want 85", ir_opcode); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL two_valid_early: got %0b want 0", instr_valid); end
    tick();  // WAIT_IMM
    tests++; if (mem_addr !== 8'h02) begin fails++; $display("FAIL two_addr_imm: got %0h want 2", mem_addr); end
    tick();  // HOLD, 4 cycles after ISSUE_OP
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL two_valid: got %0b want 1", instr_valid); end
    tests++; if (ir_opcode !== 8'h85) begin fails++; $display("FAIL two_opcode: got %0h want 85", ir_opcode); end
    tests++; if (ir_operand !== 8'h3C) begin fails++; $display("FAIL two_operand: got %0h want 3c", ir_operand); end
    tests++; if (en_cnt - en0 !== 2) begin fails++; $display("FAIL two_pc_pulses: got %0d want 2", en_cnt - en0); end
    tests++; if (pc !== 8'h03) begin fails++; $display("FAIL two_pc: got %0h want 3", pc); end
  endtask

  task automatic test_wait_states();
    int rd_cycles = 0;
    int en_cycles = 0;
    bit got = 1'b0;
    waits = 3;
    mem[8'h03] = 8'h21;
    instr_ack = 1'b1;
    tick();  // ISSUE_OP
    instr_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rd) rd_cycles++;
      if (pc_enable) en_cycles++;
      if (instr_valid) begin got = 1'b1; break; end
    end
    waits = 0;
    tests++; if (got !== 1'b1) begin fails++; $display("FAIL ws_valid_timeout: got %0b want 1", got); end
    tests++; if (rd_cycles != 4) begin fails++; $display("FAIL ws_rd_cycles: got %0d want 4", rd_cycles); end
    tests++; if (en_cycles != 1) begin fails++; $display("FAIL ws_pc_en_cycles: got %0d want 1", en_cycles); end
    tests++; if (pc !== 8'h04) begin fails++; $display("FAIL ws_pc: got %0h want 4", pc); end
    tests++; if (ir_opcode !== 8'h21) begin fails++; $display("FAIL ws_opcode: got %0h want 21", ir_opcode); end
  endtask

  task automatic test_hold_stable();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({instr_valid, ir_opcode, ir_operand, mem_rd, pc_enable} !== {1'b1, 8'h21, 8'h00, 2'b00}) begin
        fails++;
        $display("FAIL hold_stable_%0d: got v=%0b op=%0h imm=%0h rd=%0b en=%0b want v=1 op=21 imm=0 rd=0 en=0",
                 i, instr_valid, ir_opcode, ir_operand, mem_rd, pc_enable);
      end
    end
    mem[8'h04] = 8'h05;
    instr_ack = 1'b1;
    tick();  // ISSUE_OP
    instr_ack = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL hold_ack_clear: got %0b want 0", instr_valid); end
    tick();  // WAIT_OP
    tests++; if ({mem_rd, mem_addr} !== {1'b1, 8'h04}) begin fails++; $display("FAIL hold_reissue: got rd=%0b addr=%0h want rd=1 addr=4", mem_rd, mem_addr); end
    tick();  // HOLD
    tests++; if (ir_opcode !== 8'h05) begin fails++; $display("FAIL hold_next_opcode: got %0h want 05", ir_opcode); end
    instr_ack = 1'b1;
    run = 1'b0;
    tick();  // IDLE
    instr_ack = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %0b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL idle_rd_%0d: got %0b want 0", i, mem_rd); end
    end
    tests++; if (pc !== 8'h05) begin fails++; $display("FAIL idle_pc: got %0h want 5", pc); end
  endtask

  task automatic test_flush();
    int unsigned en0;
    mem[8'h10] = 8'h90;
    mem[8'h11] = 8'h44;
    mem[8'h18] = 8'h07;
    pc_load = 1'b1; pc_load_val = 8'h10;
    tick();
    pc_load = 1'b0;
    run = 1'b1;
    tick(); tick(); tick(); tick();  // ISSUE_OP, WAIT_OP, ISSUE_IMM, WAIT_IMM
    tests++; if ({mem_addr, pc} !== {8'h11, 8'h11}) begin fails++; $display("FAIL flush_setup: got addr=%0h pc=%0h want 11 11", mem_addr, pc); end
    // Decoder redirects the PC while the immediate is returning.
    flush = 1'b1;
    pc_load = 1'b1; pc_load_val = 8'h18;
    en0 = en_cnt;
    #1;
    tests++; if (pc_enable !== 1'b0) begin fails++; $display("FAIL flush_pc_en: got %0b want 0", pc_enable); end
    tick();
    flush = 1'b0; pc_load = 1'b0;
    tests++; if ({instr_valid, mem_rd} !== 2'b00) begin fails++; $display("FAIL flush_clear: got v=%0b rd=%0b want 0 0", instr_valid, mem_rd); end
    tests++; if (pc !== 8'h18) begin fails++; $display("FAIL flush_pc: got %0h want 18", pc); end
    tests++; if (en_cnt != en0) begin fails++; $display("FAIL flush_pulses: got %0d want %0d", en_cnt, en0); end
    tick();  // WAIT_OP
    tests++; if (mem_addr !== 8'h18) begin fails++; $display("FAIL flush_refetch_addr: got %0h want 18", mem_addr); end
    tick();  // HOLD
    tests++; if ({instr_valid, ir_opcode, ir_operand} !== {1'b1, 8'h07, 8'h00}) begin
      fails++; $display("FAIL flush_refetch: got v=%0b op=%0h imm=%0h want 1 07 00", instr_valid, ir_opcode, ir_operand);
    end
    // Flush in HOLD with ack also high; run low sends it to IDLE.
    flush = 1'b1; instr_ack = 1'b1; run = 1'b0;
    tick();
    flush = 1'b0; instr_ack = 1'b0;
    tick();
    tests++; if ({instr_valid, mem_rd} !== 2'b00) begin fails++; $display("FAIL flush_hold: got v=%0b rd=%0b want 0 0", instr_valid, mem_rd); end
  endtask

  task automatic test_wrap();
    mem[8'hFF] = 8'h01;
    pc_load = 1'b1; pc_load_val = 8'hFF;
    tick();
    pc_load = 1'b0;
    run = 1'b1;
    tick(); tick(); tick();  // ISSUE_OP, WAIT_OP, HOLD
    tests++; if ({mem_addr, ir_opcode, instr_valid} !== {8'hFF, 8'h01, 1'b1}) begin
      fails++; $display("FAIL wrap_fetch: got addr=%0h op=%0h v=%0b want ff 01 1", mem_addr, ir_opcode, instr_valid);
    end
    tests++; if (pc !== 8'h00) begin fails++; $display("FAIL wrap_pc: got %0h want 0", pc); end
    instr_ack = 1'b1; run = 1'b0;
    tick();
    instr_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    waits = 1000;
    run = 1'b1;
    tick(); tick(); tick(); tick();  // ISSUE_OP then WAIT_OP stalled
    tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL rstw_stall_rd: got %0b want 1", mem_rd); end
    reset = 1'b1; run = 1'b0;
    tick();
    tests++; if ({mem_addr, mem_rd, ir_opcode, ir_operand, instr_valid, fetch_err} !== 27'd0) begin
      fails++; $display("FAIL rstw_outputs: got addr=%0h rd=%0b op=%0h imm=%0h v=%0b err=%0b want all 0",
                        mem_addr, mem_rd, ir_opcode, ir_operand, instr_valid, fetch_err);
    end
    reset = 1'b0;
    waits = 0;
    tick();
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int rd_cycles = 0;
    bit got = 1'b0;
    waits = 1000;
    run = 1'b1;
    tick();  // ISSUE_OP
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_rd) rd_cycles++;
      if (fetch_err) begin got = 1'b1; break; end
    end
    run = 1'b0;
    tests++; if (got !== 1'b1) begin fails++; $display("FAIL to_err_seen: got %0b want 1", got); end
    tests++; if (rd_cycles != 16) begin fails++; $display("FAIL to_wait_cycles: got %0d want 16", rd_cycles); end
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL to_rd_drop: got %0b want 0", mem_rd); end
    tick();
    tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL to_err_pulse: got %0b want 0", fetch_err); end
    tick();
    tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL to_idle: got %0b want 0", mem_rd); end
    waits = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_wait_states();
    test_hold_stable();
    test_flush();
    test_wrap();
    test_reset_mid_wait();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1);
  end

endmodule
